// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the round-robin counter scheduler.
package counter_sched_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/counter4bit.sv
// Shared 4-bit up-counter with synchronous reset, parallel load and count enable.
module counter4bit
   import counter_sched_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] data_in,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;

   // Counter register: reset beats load, load beats increment
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= {CNT_W{1'b0}};
      end else if (load) begin
         count_q <= data_in;
      end else if (en) begin
         count_q <= count_q + CNT_W'(1);
      end else begin
         count_q <= count_q;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/counter_sched.sv
// Round-robin arbiter granting one requester at a time a run of the shared counter up to its delay.
module counter_sched
   import counter_sched_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [CNT_W*NREQ-1:0] delay,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [CNT_W-1:0]      count
);

   localparam int IDX_W = $clog2(NREQ);

   state_e           state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  done_q, done_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] w_q, w_d;
   logic [CNT_W-1:0] target_q, target_d;

   logic [IDX_W-1:0] w_s;
   logic [IDX_W-1:0] ptr_inc_s;
   logic             load_s;
   logic             req_w_s;
   logic             at_target_s;
   logic             cnt_en_s;
   logic [CNT_W-1:0] count_s;

   // First set bit at or above p, otherwise the lowest set bit (wrap-around)
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IDX_W-1:0] p);
      logic [IDX_W-1:0] hi_w, lo_w;
      logic             hi_f, lo_f;
      hi_w = {IDX_W{1'b0}};
      lo_w = {IDX_W{1'b0}};
      hi_f = 1'b0;
      lo_f = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (r[i] && !hi_f && (i >= int'(p))) begin
            hi_w = IDX_W'(i);
            hi_f = 1'b1;
         end
         if (r[i] && !lo_f) begin
            lo_w = IDX_W'(i);
            lo_f = 1'b1;
         end
      end
      return hi_f ? hi_w : lo_w;
   endfunction

   assign w_s         = rr_pick(req, ptr_q);
   assign load_s      = (state_q == IDLE) && (req != {NREQ{1'b0}});
   assign req_w_s     = req[w_q];
   assign at_target_s = (count_s == target_q);
   assign cnt_en_s    = (state_q == RUN) && !at_target_s && req_w_s;
   assign ptr_inc_s   = (w_q == IDX_W'(NREQ - 1)) ? {IDX_W{1'b0}} : w_q + IDX_W'(1);

   counter4bit u_counter (
      .clk     (clk),
      .rst     (~rst_n),
      .load    (load_s),
      .data_in ({CNT_W{1'b0}}),
      .en      (cnt_en_s),
      .count   (count_s)
   );

   // Next-state: arbitrate in IDLE; in RUN finish on target or abort on dropped request
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      done_d   = {NREQ{1'b0}};
      ptr_d    = ptr_q;
      w_d      = w_q;
      target_d = target_q;
      case (state_q)
         IDLE: begin
            gnt_d = {NREQ{1'b0}};
            if (load_s) begin
               gnt_d[w_s] = 1'b1;
               target_d   = delay[{w_s, 2'b00} +: CNT_W];
               w_d        = w_s;
               state_d    = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (!req_w_s || at_target_s) begin
               done_d  = req_w_s ? gnt_q : {NREQ{1'b0}};
               gnt_d   = {NREQ{1'b0}};
               ptr_d   = ptr_inc_s;
               state_d = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            gnt_d   = {NREQ{1'b0}};
            state_d = IDLE;
         end
      endcase
   end

   // Scheduler state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= {NREQ{1'b0}};
         done_q   <= {NREQ{1'b0}};
         ptr_q    <= {IDX_W{1'b0}};
         w_q      <= {IDX_W{1'b0}};
         target_q <= {CNT_W{1'b0}};
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         ptr_q    <= ptr_d;
         w_q      <= w_d;
         target_q <= target_d;
      end
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign busy  = (state_q == RUN);
   assign count = count_s;

endmodule

// File: tb/tb_counter_sched.sv
// Directed self-checking bench for counter_sched with hand-computed expectations.
module tb_counter_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [15:0] delay;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        busy;
   logic [3:0]  count;

   int vec_cnt = 0;
   int err_cnt = 0;

   counter_sched #(.NREQ(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .delay (delay),
      .gnt   (gnt),
      .done  (done),
      .busy  (busy),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b0000;
      delay = 16'h0000;
      tick();
      vec_cnt++;
      if ({gnt, done, busy, count} !== 13'd0) begin
         err_cnt++;
         $display("FAIL reset_state: gnt=%b done=%b busy=%b count=%0d, expected all zero", gnt, done, busy, count);
      end
      tick();
      rst_n = 1'b1;
      tick();
      vec_cnt++;
      if ({gnt, busy, count} !== 9'd0) begin
         err_cnt++;
         $display("FAIL idle_no_req: gnt=%b busy=%b count=%0d, expected zero", gnt, busy, count);
      end
   endtask

   task automatic test_single();
      delay = 16'h0005;
      req   = 4'b0001;
      tick();
      vec_cnt++;
      if (gnt !== 4'b0001 || busy !== 1'b1 || count !== 4'd0) begin
         err_cnt++;
         $display("FAIL single_grant: gnt=%b busy=%b count=%0d, expected 0001 1 0", gnt, busy, count);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         vec_cnt++;
         if (count !== 4'(k) || done !== 4'b0000 || gnt !== 4'b0001) begin
            err_cnt++;
            $display("FAIL single_count: count=%0d done=%b gnt=%b, expected %0d 0000 0001", count, done, gnt, k);
         end
      end
      tick();
      vec_cnt++;
      if (done !== 4'b0001 || gnt !== 4'b0000 || busy !== 1'b0 || count !== 4'd5) begin
         err_cnt++;
         $display("FAIL single_done: done=%b gnt=%b busy=%b count=%0d, expected 0001 0000 0 5", done, gnt, busy, count);
      end
      req = 4'b0000;
      tick();
      vec_cnt++;
      if (done !== 4'b0000 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL single_pulse: done=%b busy=%b, expected 0000 0", done, busy);
      end
   endtask

   task automatic test_zero_delay();
      delay = 16'h0000;
      req   = 4'b0010;
      tick();
      vec_cnt++;
      if (gnt !== 4'b0010 || count !== 4'd0) begin
         err_cnt++;
         $display("FAIL zero_grant: gnt=%b count=%0d, expected 0010 0", gnt, count);
      end
      tick();
      vec_cnt++;
      if (done !== 4'b0010 || gnt !== 4'b0000 || count !== 4'd0) begin
         err_cnt++;
         $display("FAIL zero_done: done=%b gnt=%b count=%0d, expected 0010 0000 0", done, gnt, count);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_oh;
      apply_reset();
      delay = 16'h2222;
      req   = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         exp_oh = 4'b0001 << (g % 4);
         tick();
         vec_cnt++;
         if (gnt !== exp_oh || done !== 4'b0000) begin
            err_cnt++;
            $display("FAIL rr_grant%0d: gnt=%b done=%b, expected %b 0000", g, gnt, done, exp_oh);
         end
         tick();
         tick();
         tick();
         vec_cnt++;
         if (done !== exp_oh || gnt !== 4'b0000 || count !== 4'd2) begin
            err_cnt++;
            $display("FAIL rr_done%0d: done=%b gnt=%b count=%0d, expected %b 0000 2", g, done, gnt, count, exp_oh);
         end
      end
      req = 4'b0000;
      tick();
      vec_cnt++;
      if (gnt !== 4'b0000 || done !== 4'b0000) begin
         err_cnt++;
         $display("FAIL rr_quiet: gnt=%b done=%b, expected 0000 0000", gnt, done);
      end
   endtask

   task automatic test_abort();
      delay = 16'h0900;
      req   = 4'b0100;
      tick();
      vec_cnt++;
      if (gnt !== 4'b0100) begin
         err_cnt++;
         $display("FAIL abort_grant: gnt=%b, expected 0100", gnt);
      end
      tick();
      tick();
      tick();
      req = 4'b0000;
      tick();
      vec_cnt++;
      if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || count !== 4'd3) begin
         err_cnt++;
         $display("FAIL abort_clear: gnt=%b done=%b busy=%b count=%0d, expected 0000 0000 0 3", gnt, done, busy, count);
      end
      tick();
      vec_cnt++;
      if (done !== 4'b0000 || count !== 4'd3) begin
         err_cnt++;
         $display("FAIL abort_hold: done=%b count=%0d, expected 0000 3", done, count);
      end
      req = 4'b1001;
      tick();
      vec_cnt++;
      if (gnt !== 4'b1000) begin
         err_cnt++;
         $display("FAIL abort_next: gnt=%b, expected 1000", gnt);
      end
      tick();
      vec_cnt++;
      if (done !== 4'b1000) begin
         err_cnt++;
         $display("FAIL abort_next_done: done=%b, expected 1000", done);
      end
      req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_run();
      delay = 16'h0009;
      req   = 4'b0001;
      tick();
      for (int k = 0; k < 7; k++) tick();
      vec_cnt++;
      if (count !== 4'd7 || gnt !== 4'b0001) begin
         err_cnt++;
         $display("FAIL midrst_pre: count=%0d gnt=%b, expected 7 0001", count, gnt);
      end
      rst_n = 1'b0;
      #1;
      vec_cnt++;
      if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
         err_cnt++;
         $display("FAIL midrst_async: gnt=%b done=%b busy=%b, expected 0000 0000 0", gnt, done, busy);
      end
      req = 4'b1000;
      tick();
      vec_cnt++;
      if (count !== 4'd0 || done !== 4'b0000) begin
         err_cnt++;
         $display("FAIL midrst_count: count=%0d done=%b, expected 0 0000", count, done);
      end
      rst_n = 1'b1;
      tick();
      vec_cnt++;
      if (gnt !== 4'b1000 || busy !== 1'b1) begin
         err_cnt++;
         $display("FAIL midrst_regrant: gnt=%b busy=%b, expected 1000 1", gnt, busy);
      end
      tick();
      req = 4'b0000;
      tick();
   endtask

   task automatic test_delay_change();
      delay = 16'h0004;
      req   = 4'b0001;
      tick();
      vec_cnt++;
      if (gnt !== 4'b0001) begin
         err_cnt++;
         $display("FAIL dchg_grant: gnt=%b, expected 0001", gnt);
      end
      delay = 16'h000C;
      for (int k = 1; k <= 4; k++) begin
         tick();
         vec_cnt++;
         if (count !== 4'(k) || done !== 4'b0000) begin
            err_cnt++;
            $display("FAIL dchg_count: count=%0d done=%b, expected %0d 0000", count, done, k);
         end
      end
      tick();
      vec_cnt++;
      if (done !== 4'b0001 || count !== 4'd4 || gnt !== 4'b0000) begin
         err_cnt++;
         $display("FAIL dchg_done: done=%b count=%0d gnt=%b, expected 0001 4 0000", done, count, gnt);
      end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b0000;
      delay = 16'h0000;
      test_reset();
      test_single();
      test_zero_delay();
      test_round_robin();
      test_abort();
      test_reset_mid_run();
      test_delay_change();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
